// File: rtl/alif_pkg.sv
// Shared types and default widths for the ALIF spike-stream decoder.
package alif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int ALIF_CNT_W = 8;
  localparam int ALIF_WIN_W = 16;
  localparam int ALIF_ISI_W = 16;

  localparam logic [ALIF_ISI_W-1:0] ISI_NONE = '1;

endpackage

// File: rtl/alif_isi_tracker.sv
// Minimum inter-spike-interval tracker; isi_min/sat present the value that
// includes the current cycle's sample so the window closer can capture it.
module alif_isi_tracker
  import alif_pkg::*;
#(
  parameter int ISI_W = ALIF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample,
  input  logic             rise,
  output logic [ISI_W-1:0] isi_min,
  output logic             sat
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;
  localparam logic [ISI_W-1:0] ISI_ONE = {{(ISI_W-1){1'b0}}, 1'b1};

  logic [ISI_W-1:0] isi_cnt, isi_cnt_nxt;
  logic [ISI_W-1:0] isi_min_r, isi_min_nxt;
  logic             isi_seen, isi_seen_nxt;
  logic             sat_r, sat_nxt;

  function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] v);
    return (v == ISI_MAX) ? v : v + ISI_ONE;
  endfunction

  function automatic logic [ISI_W-1:0] isi_umin(input logic [ISI_W-1:0] a,
                                                input logic [ISI_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  always_comb begin
    isi_cnt_nxt  = isi_cnt;
    isi_min_nxt  = isi_min_r;
    isi_seen_nxt = isi_seen;
    sat_nxt      = sat_r;
    if (clear) begin
      isi_cnt_nxt  = '0;
      isi_min_nxt  = ISI_MAX;
      isi_seen_nxt = 1'b0;
      sat_nxt      = 1'b0;
    end else if (sample) begin
      if (rise) begin
        if (isi_seen) isi_min_nxt = isi_umin(isi_min_r, isi_cnt);
        isi_cnt_nxt  = ISI_ONE;
        isi_seen_nxt = 1'b1;
      end else if (isi_seen) begin
        // Gap counter only runs once a first spike has opened an interval
        isi_cnt_nxt = isi_sat_inc(isi_cnt);
        if (isi_cnt_nxt == ISI_MAX) sat_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_cnt   <= '0;
      isi_min_r <= ISI_MAX;
      isi_seen  <= 1'b0;
      sat_r     <= 1'b0;
    end else begin
      isi_cnt   <= isi_cnt_nxt;
      isi_min_r <= isi_min_nxt;
      isi_seen  <= isi_seen_nxt;
      sat_r     <= sat_nxt;
    end
  end

  assign isi_min = isi_min_nxt;
  assign sat     = sat_nxt;

endmodule

// File: rtl/alif_spike_decoder.sv
// Windowed spike-rate and minimum-ISI decoder for the tt_um_alif spike output,
// reporting one result per window on a valid/ready port.
module alif_spike_decoder
  import alif_pkg::*;
#(
  parameter int CNT_W = ALIF_CNT_W,
  parameter int WIN_W = ALIF_WIN_W,
  parameter int ISI_W = ALIF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] rate_count,
  output logic [ISI_W-1:0] isi_min,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             spike_d;
  logic             rise;
  logic [WIN_W-1:0] rem;
  logic [CNT_W-1:0] count, count_nxt;
  logic             cnt_ovf, cnt_ovf_nxt;
  logic             win_start, sample, win_close;
  logic [ISI_W-1:0] trk_isi_min;
  logic             trk_sat;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign rise = spike_in & ~spike_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_start = 1'b0;
    sample    = 1'b0;
    win_close = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          win_start = 1'b1;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          sample = 1'b1;
          if (rem == WIN_ONE) begin
            win_close = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // Result is held regardless of en until the consumer takes it
        if (out_ready) begin
          if (en) begin
            win_start = 1'b1;
            state_nxt = COUNT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt   = count;
    cnt_ovf_nxt = cnt_ovf;
    if (sample && rise) begin
      if (count == CNT_MAX) cnt_ovf_nxt = 1'b1;
      count_nxt = cnt_sat_inc(count);
    end
  end

  alif_isi_tracker #(
    .ISI_W (ISI_W)
  ) u_isi (
    .clk     (clk),
    .rst     (rst),
    .clear   (win_start),
    .sample  (sample),
    .rise    (rise),
    .isi_min (trk_isi_min),
    .sat     (trk_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_d    <= 1'b0;
      rem        <= '0;
      count      <= '0;
      cnt_ovf    <= 1'b0;
      rate_count <= '0;
      isi_min    <= '0;
      overflow   <= 1'b0;
    end else begin
      spike_d <= spike_in;
      if (win_start) begin
        rem     <= (win_len == '0) ? WIN_ONE : win_len;
        count   <= '0;
        cnt_ovf <= 1'b0;
      end else if (sample) begin
        rem     <= rem - WIN_ONE;
        count   <= count_nxt;
        cnt_ovf <= cnt_ovf_nxt;
      end
      // Window close: capture including the final cycle's spike
      if (win_close) begin
        rate_count <= count_nxt;
        isi_min    <= trk_isi_min;
        overflow   <= cnt_ovf_nxt | trk_sat;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state == COUNT);

endmodule

// File: tb/tb_alif_spike_decoder.sv
// Directed scoreboard bench for alif_spike_decoder.
module tb_alif_spike_decoder;
  import alif_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        spike_in;
  logic [15:0] win_len;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  rate_count;
  logic [15:0] isi_min;
  logic        overflow;
  logic        busy;

  typedef struct packed {
    logic [7:0]  rate;
    logic [15:0] isi;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alif_spike_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .win_len    (win_len),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .rate_count (rate_count),
    .isi_min    (isi_min),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] r, input logic [15:0] i, input logic o);
    exp_t e;
    e.rate = r;
    e.isi  = i;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk($sformatf("%s_valid", tag), {31'd0, out_valid}, 32'd1);
    chk($sformatf("%s_sb_nonempty", tag), {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("%s_rate", tag), {24'd0, rate_count}, {24'd0, e.rate});
      chk($sformatf("%s_isi", tag), {16'd0, isi_min}, {16'd0, e.isi});
      chk($sformatf("%s_ovf", tag), {31'd0, overflow}, {31'd0, e.ovf});
      chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic start_window(input logic [15:0] len);
    win_len = len;
    en      = 1'b1;
    step();
  endtask

  // mode 0: spike_in = mask[c]; mode 1: toggle (high on odd cycles); mode 2: held high
  task automatic drive_window(input int n, input logic [31:0] mask, input int mode);
    for (int c = 1; c <= n; c++) begin
      case (mode)
        0:       spike_in = (c < 32) ? mask[c] : 1'b0;
        1:       spike_in = c[0];
        default: spike_in = 1'b1;
      endcase
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    spike_in  = 1'b0;
    win_len   = 16'd0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rate", {24'd0, rate_count}, 32'd0);
    chk("rst_isi", {16'd0, isi_min}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();

    // Basic window: spikes at 1, 3, 7 of 10
    push_exp(8'd3, 16'd2, 1'b0);
    start_window(16'd10);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    chk("basic_no_early_valid", {31'd0, out_valid}, 32'd0);
    drive_window(10, 32'h0000_008A, 0);
    en = 1'b0;
    check_result("basic");
    step();
    chk("basic_valid_pulse", {31'd0, out_valid}, 32'd0);

    // Count saturation with toggling spike
    push_exp(8'd255, 16'd2, 1'b1);
    start_window(16'd600);
    drive_window(600, 32'd0, 1);
    en = 1'b0;
    check_result("sat");
    step();

    // win_len=0 is a one-cycle window
    push_exp(8'd1, ISI_NONE, 1'b0);
    start_window(16'd0);
    drive_window(1, 32'd0, 2);
    en = 1'b0;
    check_result("len0");
    spike_in = 1'b0;
    step();

    // No spikes
    push_exp(8'd0, ISI_NONE, 1'b0);
    start_window(16'd5);
    drive_window(5, 32'd0, 0);
    en = 1'b0;
    check_result("nospike");
    step();

    // Backpressure, later gap is the minimum
    push_exp(8'd3, 16'd3, 1'b0);
    start_window(16'd8);
    drive_window(8, 32'h0000_0122, 0);
    out_ready = 1'b0;
    check_result("bp");
    for (int k = 0; k < 5; k++) begin
      spike_in = ~k[0];
      step();
      chk($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rate", k), {24'd0, rate_count}, 32'd3);
      chk($sformatf("bp_hold%0d_isi", k), {16'd0, isi_min}, 32'd3);
    end
    push_exp(8'd0, ISI_NONE, 1'b0);
    out_ready = 1'b1;
    win_len   = 16'd4;
    step();
    chk("bp_restart_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_restart_busy", {31'd0, busy}, 32'd1);
    drive_window(4, 32'd0, 2);
    en = 1'b0;
    check_result("bp_next");
    spike_in = 1'b0;
    step();

    // Abort in window cycle 4
    start_window(16'd10);
    drive_window(3, 32'h0000_000A, 0);
    en       = 1'b0;
    spike_in = 1'b0;
    step();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("abort_valid%0d", k), {31'd0, out_valid}, 32'd0);
    end
    chk("abort_rate_kept", {24'd0, rate_count}, 32'd0);
    chk("abort_isi_kept", {16'd0, isi_min}, {16'd0, ISI_NONE});
    push_exp(8'd1, ISI_NONE, 1'b0);
    start_window(16'd3);
    drive_window(3, 32'h0000_0004, 0);
    en = 1'b0;
    check_result("after_abort");
    step();

    // Asynchronous reset mid-window with two spikes counted
    push_exp(8'd2, 16'd3, 1'b0);
    start_window(16'd10);
    drive_window(4, 32'h0000_000A, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_rate", {24'd0, rate_count}, 32'd0);
    chk("arst_isi", {16'd0, isi_min}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    en = 1'b0;
    step();
    rst = 1'b0;
    step();
    start_window(16'd6);
    drive_window(6, 32'h0000_0012, 0);
    en = 1'b0;
    check_result("post_rst");
    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
